instruction_fetch: RTL and testbench

Fetch stage of the five-stage pipeline. Owns the program counter, drives the instruction-memory request port, and owns the IF/ID pipeline register. It is the direct consumer of the hazard unit's `pcWrite`/`ifIdWrite` stall controls. A taken branch resolved downstream redirects it and flushes IF/ID. A one-entry hold buffer absorbs memory responses that arrive while decode is stalled, so no fetched word is lost or re-requested.

---
 rtl/instruction_fetch.sv | 146 ++++++++++++++
 tb/tb_instruction_fetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues instruction-memory requests,
// parks a returned word in a one-entry hold buffer while decode is stalled,
// and drives the IF/ID pipeline register. Taken branches redirect the PC and
// flush IF/ID; a miss-in-flight redirect waits in DRAIN for the stale reply.
//
// Memory handshake: imemReq is a valid; imemAddr is held stable while imemReq
// is high until the cycle imemReady is seen high, which completes the transfer
// and carries imemData. imemReady may be high in the same cycle as imemReq.
// imemReq/imemAddr depend on registered state and pc only.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        pcWrite,
    input  logic        ifIdWrite,
    input  logic        branchTaken,
    input  logic [31:0] branchTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] ifIdInstr,
    output logic [31:0] ifIdPcPlus4,
    output logic        ifIdValid,
    output logic [1:0]  fsmState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetchStateT;

    fetchStateT  state;
    logic [31:0] pc;
    logic [31:0] redirect;
    logic [31:0] bufInstr;
    logic [31:0] bufPcPlus4;

    logic        accept;
    logic        fetchHit;
    logic        avail;
    logic [31:0] pcPlus4;
    logic [31:0] availInstr;
    logic [31:0] availPcPlus4;

    // Decode the request port and the word (if any) that could enter IF/ID now.
    always_comb begin
        accept       = pcWrite & ifIdWrite;
        fetchHit     = (state == FETCH) & imemReady;
        avail        = fetchHit | (state == HOLD);
        pcPlus4      = pc + 32'd4;
        imemReq      = (state == FETCH) || (state == DRAIN);
        imemAddr     = pc;
        fsmState     = state;
        availInstr   = imemData;
        availPcPlus4 = pcPlus4;
        if (state == HOLD) begin
            availInstr   = bufInstr;
            availPcPlus4 = bufPcPlus4;
        end
    end

    // Fetch FSM: PC, redirect target and hold buffer; branches override stalls.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            redirect   <= 32'd0;
            bufInstr   <= 32'd0;
            bufPcPlus4 <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (branchTaken) pc <= branchTarget;
                    state <= FETCH;
                end
                FETCH: begin
                    if (branchTaken) begin
                        if (imemReady) begin
                            pc <= branchTarget;
                        end else begin
                            // Request already on the bus: keep the address
                            // until its reply arrives, then jump.
                            redirect <= branchTarget;
                            state    <= DRAIN;
                        end
                    end else if (imemReady) begin
                        if (accept) begin
                            pc <= pcPlus4;
                        end else begin
                            bufInstr   <= imemData;
                            bufPcPlus4 <= pcPlus4;
                            state      <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (branchTaken) begin
                        bufInstr   <= 32'd0;
                        bufPcPlus4 <= 32'd0;
                        pc         <= branchTarget;
                        state      <= FETCH;
                    end else if (accept) begin
                        pc    <= pcPlus4;
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    if (branchTaken) redirect <= branchTarget;
                    if (imemReady) begin
                        pc    <= branchTaken ? branchTarget : redirect;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // IF/ID register: flush on branch, load a word on accept, bubble otherwise.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ifIdInstr   <= NOP;
            ifIdPcPlus4 <= 32'd0;
            ifIdValid   <= 1'b0;
        end else if (branchTaken) begin
            ifIdInstr   <= NOP;
            ifIdPcPlus4 <= 32'd0;
            ifIdValid   <= 1'b0;
        end else if (ifIdWrite) begin
            if (avail && pcWrite) begin
                ifIdInstr   <= availInstr;
                ifIdPcPlus4 <= availPcPlus4;
                ifIdValid   <= 1'b1;
            end else begin
                ifIdInstr <= NOP;
                ifIdValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed walk through the fetch scenarios plus
// randomized stall/wait/branch/reset traffic, scored against a transaction
// model of the fetch stage.
module tb_instruction_fetch;

    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam logic [31:0] NOPW = 32'h0000_0013;
    localparam int          EW   = 98;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        pcWrite = 1'b1;
    logic        ifIdWrite = 1'b1;
    logic        branchTaken = 1'b0;
    logic [31:0] branchTarget = 32'd0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady = 1'b0;
    logic [31:0] imemData;
    logic [31:0] ifIdInstr;
    logic [31:0] ifIdPcPlus4;
    logic        ifIdValid;
    logic [1:0]  fsmState;

    int nVec = 0;
    int nErr = 0;

    // Expected queue: {instr, pcPlus4, valid, req, addr} after each edge.
    logic [EW-1:0] expQ[$];

    instruction_fetch #(.RESET_PC(RPC), .NOP(NOPW)) dut (
        .clk(clk), .rstN(rstN), .pcWrite(pcWrite), .ifIdWrite(ifIdWrite),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady),
        .imemData(imemData), .ifIdInstr(ifIdInstr), .ifIdPcPlus4(ifIdPcPlus4),
        .ifIdValid(ifIdValid), .fsmState(fsmState)
    );

    // Clock.
    always #5 clk = ~clk;

    // Memory content is a fixed scramble of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A17} + 32'd1;
    endfunction
    assign imemData = memWord(imemAddr);

    // Reference model: where the stage will fetch next, whether a word is
    // parked, whether a stale reply must be thrown away, and the IF/ID view.
    logic        mIdle;
    logic [31:0] mNext;
    logic        mParked;
    logic [31:0] mParkWord, mParkPc4;
    logic        mStale;
    logic [31:0] mJumpTo;
    logic [31:0] mInstr, mPc4;
    logic        mValid;

    task automatic modelReset();
        mIdle = 1'b1; mNext = RPC; mParked = 1'b0; mParkWord = 0; mParkPc4 = 0;
        mStale = 1'b0; mJumpTo = 0; mInstr = NOPW; mPc4 = 0; mValid = 1'b0;
    endtask

    task automatic modelStep(input logic pw, input logic iw, input logic br,
                             input logic [31:0] tgt, input logic rdy);
        logic onBus, haveWord;
        logic [31:0] w, w4;
        onBus    = !mIdle && !mParked;
        haveWord = mParked || (onBus && !mStale && rdy);
        w  = mParked ? mParkWord : memWord(mNext);
        w4 = mParked ? mParkPc4  : mNext + 32'd4;
        if (br) begin
            mInstr = NOPW; mPc4 = 0; mValid = 1'b0;
        end else if (iw) begin
            if (haveWord && pw) begin mInstr = w; mPc4 = w4; mValid = 1'b1; end
            else begin mInstr = NOPW; mValid = 1'b0; end
        end
        if (mIdle) begin
            mIdle = 1'b0;
            if (br) mNext = tgt;
        end else if (mStale) begin
            if (br) mJumpTo = tgt;
            if (rdy) begin mNext = mJumpTo; mStale = 1'b0; end
        end else if (br) begin
            if (mParked || rdy) mNext = tgt;
            else begin mStale = 1'b1; mJumpTo = tgt; end
            mParked = 1'b0;
        end else if (mParked) begin
            if (pw && iw) begin mNext = mNext + 32'd4; mParked = 1'b0; end
        end else if (rdy) begin
            if (pw && iw) mNext = mNext + 32'd4;
            else begin mParked = 1'b1; mParkWord = w; mParkPc4 = w4; end
        end
    endtask

    // Driver: one cycle of stimulus applied at the falling edge.
    task automatic cyc(input logic pw, input logic iw, input logic br,
                       input logic [31:0] tgt, input logic rdy);
        @(negedge clk);
        pcWrite = pw; ifIdWrite = iw; branchTaken = br;
        branchTarget = tgt; imemReady = rdy;
        modelStep(pw, iw, br, tgt, rdy);
        expQ.push_back({mInstr, mPc4, mValid, !mIdle && !mParked, mNext});
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear at once.
    task automatic doReset();
        @(posedge clk);
        #2;
        rstN = 1'b0;
        branchTaken = 1'b0;
        #1;
        nVec++;
        if (imemReq !== 1'b0 || ifIdInstr !== NOPW || ifIdPcPlus4 !== 32'd0 ||
            ifIdValid !== 1'b0) begin
            nErr++;
            $display("FAIL reset_async: got req=%b instr=%h pc4=%h valid=%b, want req=0 instr=%h pc4=0 valid=0",
                     imemReq, ifIdInstr, ifIdPcPlus4, ifIdValid, NOPW);
        end
        expQ.delete();
        modelReset();
        @(posedge clk);
        #2;
        rstN = 1'b1;
    endtask

    // Scoreboard monitor: compare DUT state after every edge that has an entry.
    initial begin
        logic [EW-1:0] e;
        logic ok;
        forever begin
            @(posedge clk);
            #1;
            if (rstN && expQ.size() > 0) begin
                e = expQ.pop_front();
                nVec++;
                ok = (ifIdInstr === e[97:66]) && (ifIdPcPlus4 === e[65:34]) &&
                     (ifIdValid === e[33]) && (imemReq === e[32]) &&
                     (!e[32] || imemAddr === e[31:0]);
                if (!ok) begin
                    nErr++;
                    $display("FAIL ifid_port @%0t: got instr=%h pc4=%h v=%b req=%b addr=%h, want instr=%h pc4=%h v=%b req=%b addr=%h",
                             $time, ifIdInstr, ifIdPcPlus4, ifIdValid, imemReq, imemAddr,
                             e[97:66], e[65:34], e[33], e[32], e[31:0]);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic, then report.
    initial begin
        logic [31:0] t;
        modelReset();
        doReset();
        // Zero-wait fetches from RESET_PC.
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        // Two wait cycles, then the word lands.
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 1);
        // Stall three cycles while the next word returns, then release.
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 1);
        // Branch while waiting: drain the stale reply, then fetch 0x400.
        cyc(1, 1, 1, 32'h400, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        // Park a word, then branch to 0x200 with IF/ID stalled.
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 1, 32'h200, 0);
        cyc(1, 1, 0, 0, 1);
        // PC wrap at the top of the address space.
        cyc(1, 1, 1, 32'hFFFF_FFFC, 1);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        // Enter DRAIN and reset in the middle of it.
        cyc(1, 1, 1, 32'h800, 0);
        cyc(1, 1, 0, 0, 0);
        doReset();
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) doReset();
            case ($urandom_range(0, 3))
                0:       t = 32'hFFFF_FFF8;
                default: t = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            endcase
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 8,
                $urandom_range(0, 9) == 0, t, $urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        pcWrite = 1'b1; ifIdWrite = 1'b1; branchTaken = 1'b0;
        @(posedge clk);
        #2;
        nVec++;
        if (expQ.size() != 0) begin
            nErr++;
            $display("FAIL queue_drain: got %0d pending, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
